// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS32 main controller FSM with memory wait states and retire counter
// Optional macro MC_CTRL_JUMP_EN builds the JUMP state; without it j decodes as illegal.
module mips_mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [1:0]       PCSource,
  output logic [2:0]       AluOp,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EX     = 4'd10,
    S_I_WB     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  // Branch resolution happens in the datapath; the controller never looks at Zero.
  logic unused_zero;
  assign unused_zero = Zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    PCSource    = 2'b00;
    AluOp       = 3'b000;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        AluSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        AluSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:              state_d = S_MEM_ADDR;
          OP_R:                      state_d = S_R_EX;
          OP_BEQ:                    state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_I_EX;
`ifdef MC_CTRL_JUMP_EN
          OP_J:                      state_d = S_JUMP;
`else
          OP_J:                      state_d = S_ILLEGAL;
`endif
          default:                   state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        state_d = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_EX: begin
        AluSrcA = 1'b1;
        AluOp   = 3'b010;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_I_EX: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        case (Opcode)
          OP_ANDI: AluOp = 3'b011;
          OP_ORI:  AluOp = 3'b100;
          default: AluOp = 3'b000;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        AluSrcA     = 1'b1;
        AluOp       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    retired_d = retire ? retired_q + CNT_ONE : retired_q;
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - table-driven scoreboard bench for mips_mc_ctrl (honours MC_CTRL_JUMP_EN)
module tb_mips_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  Opcode;
  logic        Zero;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegWrite, RegDst, AluSrcA, illegal;
  logic [1:0]  AluSrcB, PCSource;
  logic [2:0]  AluOp;
  logic [3:0]  state;
  logic [31:0] retired;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .RegDst(RegDst), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .PCSource(PCSource),
    .AluOp(AluOp), .state(state), .illegal(illegal), .retired(retired)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic       ill;
  } obs_t;

  // path holds up to six state codes, first state in the top nibble
  typedef struct {
    logic [5:0]  op;
    logic        zero;
    int          fw;
    int          mw;
    logic [23:0] path;
    int          plen;
    int          ret;
  } vec_t;

  obs_t act;
  assign act = '{state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegWrite, RegDst, AluSrcA, AluSrcB, PCSource, AluOp, illegal};

  obs_t sb_q[$];
  vec_t vecs[13];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   exp_ret = 0;

  function automatic obs_t expect_of(logic [3:0] st, logic [5:0] op, logic rdy);
    obs_t e;
    e = '0;
    e.st = st;
    case (st)
      4'd0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      4'd1:  e.alu_src_b = 2'b11;
      4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      4'd3:  begin e.mem_read = 1; e.iord = 1; end
      4'd4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      4'd5:  begin e.mem_write = 1; e.iord = 1; end
      4'd6:  begin e.alu_src_a = 1; e.alu_op = 3'b010; end
      4'd7:  begin e.reg_write = 1; e.reg_dst = 1; end
      4'd8:  begin e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_write_cond = 1; e.pc_source = 2'b01; end
      4'd9:  begin e.pc_write = 1; e.pc_source = 2'b10; end
      4'd10: begin
        e.alu_src_a = 1; e.alu_src_b = 2'b10;
        e.alu_op = (op == 6'b001100) ? 3'b011 : (op == 6'b001101) ? 3'b100 : 3'b000;
      end
      4'd11: e.reg_write = 1;
      4'd12: e.ill = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic cmp_obs(input string name, input obs_t got, input obs_t want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h required %h (state got %0d required %0d)", name, got, want, got.st, want.st);
    end
  endtask

  task automatic cmp_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [3:0] st;
    logic       rdy;
    int         waits;
    obs_t       e;
    for (int p = 0; p < v.plen; p++) begin
      st = v.path[4*(5-p) +: 4];
      waits = (st == 4'd0) ? v.fw : (st == 4'd3 || st == 4'd5) ? v.mw : 0;
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        if (st == 4'd0 || st == 4'd3 || st == 4'd5) rdy = (w == waits);
        else rdy = 1'($urandom_range(1, 0));
        Opcode = v.op;
        Zero = v.zero;
        mem_ready = rdy;
        sb_q.push_back(expect_of(st, v.op, rdy));
        #1;
        if (p == 0 && w == 0) cmp_val($sformatf("v%0d_retired_start", idx), retired, exp_ret);
        e = sb_q.pop_front();
        cmp_obs($sformatf("v%0d_p%0d_w%0d", idx, p, w), act, e);
      end
    end
    exp_ret += v.ret;
  endtask

  initial begin
    vecs[0]  = '{6'b000000, 1'b0, 0, 0, {4'd0, 4'd1, 4'd6, 4'd7, 8'h00}, 4, 1};
    vecs[1]  = '{6'b100011, 1'b0, 2, 3, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 5, 1};
    vecs[2]  = '{6'b000100, 1'b1, 0, 0, {4'd0, 4'd1, 4'd8, 12'h000}, 3, 1};
    vecs[3]  = '{6'b000100, 1'b0, 0, 0, {4'd0, 4'd1, 4'd8, 12'h000}, 3, 1};
    vecs[4]  = '{6'b001101, 1'b0, 0, 0, {4'd0, 4'd1, 4'd10, 4'd11, 8'h00}, 4, 1};
    vecs[5]  = '{6'b001100, 1'b0, 0, 0, {4'd0, 4'd1, 4'd10, 4'd11, 8'h00}, 4, 1};
    vecs[6]  = '{6'b001000, 1'b0, 0, 0, {4'd0, 4'd1, 4'd10, 4'd11, 8'h00}, 4, 1};
    vecs[7]  = '{6'b111111, 1'b0, 0, 0, {4'd0, 4'd1, 4'd12, 12'h000}, 3, 0};
`ifdef MC_CTRL_JUMP_EN
    vecs[8]  = '{6'b000010, 1'b0, 0, 0, {4'd0, 4'd1, 4'd9, 12'h000}, 3, 1};
`else
    vecs[8]  = '{6'b000010, 1'b0, 0, 0, {4'd0, 4'd1, 4'd12, 12'h000}, 3, 0};
`endif
    vecs[9]  = '{6'b100011, 1'b0, 0, 0, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 5, 1};
    vecs[10] = '{6'b101011, 1'b0, 0, 0, {4'd0, 4'd1, 4'd2, 4'd5, 8'h00}, 4, 1};
    vecs[11] = '{6'b101011, 1'b0, 1, 2, {4'd0, 4'd1, 4'd2, 4'd5, 8'h00}, 4, 1};
    vecs[12] = '{6'b000000, 1'b0, 1, 0, {4'd0, 4'd1, 4'd6, 4'd7, 8'h00}, 4, 1};

    rst_n = 1'b0;
    mem_ready = 1'b1;
    Opcode = 6'b000000;
    Zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    cmp_obs("reset_outputs", act, expect_of(4'd0, 6'b000000, 1'b1));
    cmp_val("reset_retired", retired, 0);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    cmp_val("final_state", {28'd0, state}, 0);
    cmp_val("final_retired", retired, exp_ret);

    // sw parked in MEM_WR, then asynchronous reset between clock edges
    Opcode = 6'b101011;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    cmp_val("memwr_state", {28'd0, state}, 5);
    cmp_val("memwr_write", {31'd0, MemWrite}, 1);
    rst_n = 1'b0;
    #1;
    cmp_val("abort_memwrite", {31'd0, MemWrite}, 0);
    cmp_val("abort_state", {28'd0, state}, 0);
    cmp_val("abort_retired", retired, 0);
    exp_ret = 0;
    #1;
    rst_n = 1'b1;
    run_vec(13, vecs[0]);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    cmp_val("post_abort_retired", retired, exp_ret);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
